// File: rtl/mdl_pkg_bubble.sv
// ============================================================================
// Module   : mdl_pkg_bubble
// Brief    : Shared phase constants and helpers for the bubble page path.
// Revision : 1.0
// ============================================================================
`default_nettype none

package mdl_pkg_bubble;

    localparam int         P_W_DEF   = 12;
    localparam logic [4:0] PH_SHIFT0 = 5'd0;
    localparam logic [4:0] PH_CMP    = 5'd12;
    localparam logic [4:0] PH_LOAD   = 5'd19;

    function automatic logic phase_active(input logic        pcen_n,
                                          input logic [19:0] rot_n,
                                          input logic [4:0]  k);
        return !pcen_n && !rot_n[k];
    endfunction

    // Low w bits set: the phases during which the serial registers rotate.
    function automatic logic [19:0] shift_mask(input int w);
        return 20'((21'd1 << w) - 21'd1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/mdl_serial_rotreg.sv
// ============================================================================
// Module   : mdl_serial_rotreg
// Brief    : Right-shifting serial register with parallel load.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mdl_serial_rotreg #(
    parameter int           W       = 12,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         shift_en,
    input  logic         ser_in,
    input  logic         load_en,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] q
);

    // Load wins over shift; the caller feeds q[0] back as ser_in for a pure rotate.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= RST_VAL;
        end else if (load_en) begin
            q <= load_val;
        end else if (shift_en) begin
            q <= {ser_in, q[W-1:1]};
        end
    end

endmodule

`default_nettype wire

// File: rtl/mdl_pgcmp.sv
// ============================================================================
// Module   : mdl_pgcmp
// Brief    : Page-number serializer and bubble page-position comparator.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mdl_pgcmp
    import mdl_pkg_bubble::*;
#(
    parameter int             P_W       = P_W_DEF,
    parameter logic [P_W-1:0] P_PAGES   = 12'd2052,
    parameter logic [P_W-1:0] P_INVALPG = 12'd2048
) (
    input  logic           i_MCLK,
    input  logic           i_RST,
    input  logic           i_CLK2M_PCEN_n,
    input  logic [19:0]    i_ROT20_n,
    input  logic           i_PGREG_WR,
    input  logic [P_W-1:0] i_PGREG_D,
    input  logic           i_PGADV,
    output logic           o_PGREG_SR_LSB,
    output logic           o_INVALPG_LSB,
    output logic           o_PGCMP_EQ,
    output logic [P_W-1:0] o_PGPOS
);

    logic [P_W-1:0] pgreg, thr, cnt, hold, pg_load_val;
    logic           wr_pend, adv_pend, carry, carry_in;
    logic           eq_acc, frame_valid, frame_run, eq_flag;
    logic           ph0, ph_cmp, ph_load, shift_ph, shift_en;
    logic           pg_load, cnt_wrap;

    assign ph0      = phase_active(i_CLK2M_PCEN_n, i_ROT20_n, PH_SHIFT0);
    assign ph_cmp   = phase_active(i_CLK2M_PCEN_n, i_ROT20_n, PH_CMP);
    assign ph_load  = phase_active(i_CLK2M_PCEN_n, i_ROT20_n, PH_LOAD);
    assign shift_ph = !i_CLK2M_PCEN_n && |(~i_ROT20_n & shift_mask(P_W));

    // After reset nothing shifts until a phase 0 is seen, keeping the serial
    // registers in parallel alignment when reset is released mid-frame.
    assign shift_en = shift_ph && (ph0 || frame_run);

    assign pg_load     = ph_load && (wr_pend || i_PGREG_WR);
    assign pg_load_val = i_PGREG_WR ? i_PGREG_D : hold;

    // The phase-0 increment consumes the advance request directly, so an
    // advance in the phase-0 cycle itself lands in this frame.
    assign carry_in = ph0 ? (adv_pend | i_PGADV) : carry;
    assign cnt_wrap = ph_cmp && (cnt > P_PAGES);

    mdl_serial_rotreg #(.W(P_W), .RST_VAL('0)) u_page (
        .clk      (i_MCLK),
        .rst      (i_RST),
        .shift_en (shift_en),
        .ser_in   (pgreg[0]),
        .load_en  (pg_load),
        .load_val (pg_load_val),
        .q        (pgreg)
    );

    mdl_serial_rotreg #(.W(P_W), .RST_VAL(P_INVALPG)) u_thr (
        .clk      (i_MCLK),
        .rst      (i_RST),
        .shift_en (shift_en),
        .ser_in   (thr[0]),
        .load_en  (1'b0),
        .load_val ('0),
        .q        (thr)
    );

    mdl_serial_rotreg #(.W(P_W), .RST_VAL('0)) u_cnt (
        .clk      (i_MCLK),
        .rst      (i_RST),
        .shift_en (shift_en),
        .ser_in   (cnt[0] ^ carry_in),
        .load_en  (cnt_wrap),
        .load_val ('0),
        .q        (cnt)
    );

    always_ff @(posedge i_MCLK or posedge i_RST) begin
        if (i_RST) begin
            hold     <= '0;
            wr_pend  <= 1'b0;
            adv_pend <= 1'b0;
        end else begin
            if (i_PGREG_WR) begin
                hold <= i_PGREG_D;
            end
            if (ph_load) begin
                wr_pend <= 1'b0;
            end else if (i_PGREG_WR) begin
                wr_pend <= 1'b1;
            end
            if (ph0) begin
                adv_pend <= 1'b0;
            end else if (i_PGADV) begin
                adv_pend <= 1'b1;
            end
        end
    end

    always_ff @(posedge i_MCLK or posedge i_RST) begin
        if (i_RST) begin
            carry       <= 1'b0;
            eq_acc      <= 1'b0;
            frame_valid <= 1'b0;
            frame_run   <= 1'b0;
            eq_flag     <= 1'b0;
        end else begin
            if (shift_en) begin
                carry <= cnt[0] & carry_in;
            end
            if (ph0) begin
                frame_run <= 1'b1;
            end
            if (ph_load) begin
                eq_acc      <= 1'b1;
                frame_valid <= 1'b1;
            end else if (shift_en) begin
                eq_acc <= eq_acc & (pgreg[0] == cnt[0]);
            end
            if (ph_cmp) begin
                eq_flag <= eq_acc & frame_valid;
            end
        end
    end

    assign o_PGREG_SR_LSB = pgreg[0];
    assign o_INVALPG_LSB  = thr[0];
    assign o_PGCMP_EQ     = eq_flag;
    assign o_PGPOS        = cnt;

endmodule

`default_nettype wire
